// File: rtl/cache_refill.sv
// cache_refill: on a cache miss, reads one line from memory one word at a time.
// It then writes the assembled {tag, data, valid} line into the cache with one strobe.
// If memory stalls too long, the refill is abandoned without a line write.
module cache_refill #(
  parameter int WORD_SIZE      = 32,
  parameter int INDEX_BITS     = 5,
  parameter int BLOCK_OFFSET   = 6,
  parameter int TAG_BITS       = 32 - INDEX_BITS - BLOCK_OFFSET,
  parameter int STATUS_BITS    = 1,
  parameter int LINE_LENGTH    = TAG_BITS + 8 * 2**BLOCK_OFFSET + STATUS_BITS,
  parameter int WORDS_PER_LINE = 2**BLOCK_OFFSET / 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [31:0]            miss_addr,
  output logic                   busy,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
  output logic                   full_line_wr,
  output logic [LINE_LENGTH-1:0] new_cache_line,
  output logic [31:0]            cache_addr,
  output logic                   refill_done,
  output logic                   refill_err
);

  localparam int DATA_BITS = 8 * 2**BLOCK_OFFSET;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  localparam logic [31:0] ALIGN_MASK = 32'(2**BLOCK_OFFSET - 1);
  localparam logic [3:0]  LAST_WORD  = 4'(WORDS_PER_LINE - 1);
  localparam logic [7:0]  TMO_LIMIT  = 8'(TIMEOUT_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [31:0]            base_q, base_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             tmo_q, tmo_d;
  logic [DATA_BITS-1:0]   buf_q, buf_d;

  // Output registers; their next values are decoded from the next state.
  // This makes every output change on the same edge as the state.
  logic                   busy_q, mem_req_q, flw_q, done_q, err_q;
  logic                   busy_d, mem_req_d, flw_d, done_d, err_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            caddr_q, caddr_d;
  logic [LINE_LENGTH-1:0] line_q, line_d;

  // Next-state logic: request capture, word collection, and stall timeout.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (miss_req) begin
          base_d  = miss_addr & ~ALIGN_MASK;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          buf_d[cnt_q*WORD_SIZE +: WORD_SIZE] = mem_rdata;
          tmo_d = '0;
          if (cnt_q == LAST_WORD) state_d = FILL;
          else                    cnt_d   = cnt_q + 4'd1;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO_LIMIT) state_d = ERR;
        end
      end
      FILL:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state.
  // The line and the cache address are updated only when entering FILL.
  always_comb begin
    busy_d     = (state_d != IDLE);
    mem_req_d  = (state_d == FETCH);
    mem_addr_d = (state_d == FETCH) ? base_d + 32'({cnt_d, 2'b00}) : '0;
    flw_d      = (state_d == FILL);
    done_d     = (state_q == FILL) && (state_d == IDLE);
    err_d      = (state_d == ERR);
    line_d     = line_q;
    caddr_d    = caddr_q;
    if (state_d == FILL) begin
      line_d  = {base_d[31 -: TAG_BITS], buf_d, STATUS_BITS'(1)};
      caddr_d = base_d;
    end
  end

  // Control state and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      flw_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      caddr_q    <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      flw_q      <= flw_d;
      done_q     <= done_d;
      err_q      <= err_d;
      caddr_q    <= caddr_d;
      line_q     <= line_d;
    end
  end

  // Word buffer.
  // It has no reset because every word is written before the line is exposed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy           = busy_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign full_line_wr   = flw_q;
  assign refill_done    = done_q;
  assign refill_err     = err_q;
  assign cache_addr     = caddr_q;
  assign new_cache_line = line_q;

endmodule

// File: tb/tb_cache_refill.sv
// Testbench for cache_refill.
// It uses a table of per-cycle vectors for a plain refill, plus directed sequences
// for slow memory, timeout, ignored requests, back-to-back misses and reset abort.
module tb_cache_refill;
  localparam int LL = 534;

  logic          clk = 1'b0;
  logic          rst, miss_req, mem_ready;
  logic [31:0]   miss_addr, mem_rdata, mem_addr, cache_addr;
  logic          busy, mem_req, full_line_wr, refill_done, refill_err;
  logic [LL-1:0] new_cache_line;
  logic [31:0]   data_base;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word holds data_base plus its index within the line.
  assign mem_rdata = data_base + ((mem_addr >> 2) & 32'hF);

  cache_refill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .full_line_wr(full_line_wr),
    .new_cache_line(new_cache_line), .cache_addr(cache_addr),
    .refill_done(refill_done), .refill_err(refill_err)
  );

  typedef struct {
    logic        mreq;
    logic [31:0] maddr;
    logic [36:0] exp;   // {busy, mem_req, full_line_wr, refill_done, refill_err, mem_addr}
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] outs();
    return {busy, mem_req, full_line_wr, refill_done, refill_err, mem_addr};
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return new_cache_line[32*i+1 +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  nacc, nflw, stalls, ph, fl_cyc, dn_cyc, cnt;
    bit  seen;

    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; mem_ready = 1'b0;
    data_base = 32'hA000_0000;

    // Plain refill with memory always ready.
    tbl[0] = '{1'b1, 32'h0000_1234, {5'b00000, 32'h0}};
    for (int k = 1; k <= 16; k++)
      tbl[k] = '{1'b0, 32'h0, {5'b11000, 32'h1200 + 32'(4*(k-1))}};
    tbl[17] = '{1'b0, 32'h0, {5'b10100, 32'h0}};
    tbl[18] = '{1'b0, 32'h0, {5'b00010, 32'h0}};
    tbl[19] = '{1'b0, 32'h0, {5'b00000, 32'h0}};

    repeat (2) @(negedge clk);
    check("rst_outs", 64'(outs()), 64'h0);
    check("rst_line_zero", 64'(|new_cache_line), 64'h0);
    check("rst_cache_addr", 64'(cache_addr), 64'h0);
    rst = 1'b0;
    mem_ready = 1'b1;

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("t1_cyc%0d", k), 64'(outs()), 64'(tbl[k].exp));
      if (k == 17) begin
        check("t1_tag", 64'(new_cache_line[LL-1 -: 21]), 64'h2);
        check("t1_word5", 64'(word_of(5)), 64'hA000_0005);
        check("t1_word15", 64'(word_of(15)), 64'hA000_000F);
        check("t1_valid", 64'(new_cache_line[0]), 64'h1);
        check("t1_cache_addr", 64'(cache_addr), 64'h1200);
      end
      if (k == 19) begin
        check("t1_hold_word5", 64'(word_of(5)), 64'hA000_0005);
        check("t1_hold_cache_addr", 64'(cache_addr), 64'h1200);
      end
      miss_req  = tbl[k].mreq;
      miss_addr = tbl[k].maddr;
    end

    // Slow memory: ready only every third cycle.
    data_base = 32'h5500_0000;
    mem_ready = 1'b0;
    @(negedge clk); miss_req = 1'b1; miss_addr = 32'h0000_ABCD;
    @(negedge clk); miss_req = 1'b0;
    nacc = 0; nflw = 0; ph = 0; fl_cyc = -1; dn_cyc = -1; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (full_line_wr) begin nflw++; fl_cyc = c; end
      if (refill_done) begin seen = 1'b1; dn_cyc = c; end
      mem_ready = (ph % 3 == 2);
      ph++;
      if (mem_req && mem_ready) begin
        check($sformatf("t2_addr%0d", nacc), 64'(mem_addr), 64'(32'hABC0 + 32'(4*nacc)));
        nacc++;
      end
      @(negedge clk);
      if (seen) break;
    end
    mem_ready = 1'b0;
    check("t2_done_seen", 64'(seen), 64'h1);
    check("t2_words_accepted", 64'(nacc), 64'd16);
    check("t2_flw_count", 64'(nflw), 64'd1);
    check("t2_done_after_flw", 64'(dn_cyc - fl_cyc), 64'd1);
    for (int i = 0; i < 16; i++)
      check($sformatf("t2_word%0d", i), 64'(word_of(i)), 64'(32'h5500_0000 + 32'(i)));
    check("t2_tag", 64'(new_cache_line[LL-1 -: 21]), 64'h15);
    check("t2_cache_addr", 64'(cache_addr), 64'hABC0);

    // Timeout: four words arrive, then memory goes silent.
    data_base = 32'hA000_0000;
    @(negedge clk); miss_req = 1'b1; miss_addr = 32'h0000_4000;
    @(negedge clk); miss_req = 1'b0;
    stalls = 0; nacc = 0; nflw = 0; seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (full_line_wr) nflw++;
      if (refill_err) begin
        seen = 1'b1;
        check("t3_err_busy", 64'(busy), 64'h1);
        check("t3_err_no_memreq", 64'(mem_req), 64'h0);
        check("t3_err_no_flw", 64'(full_line_wr), 64'h0);
        break;
      end
      mem_ready = (nacc < 4);
      if (mem_req) begin
        if (mem_ready) nacc++;
        else stalls++;
      end
      @(negedge clk);
    end
    check("t3_err_seen", 64'(seen), 64'h1);
    check("t3_stall_cycles", 64'(stalls), 64'd255);
    check("t3_words_before_stall", 64'(nacc), 64'd4);
    check("t3_flw_never", 64'(nflw), 64'd0);
    check("t3_line_untouched", 64'(word_of(0)), 64'h5500_0000);
    @(negedge clk);
    check("t3_after_err_outs", 64'(outs()), 64'h0);

    // Request ignored while busy; back-to-back miss in the refill_done cycle.
    mem_ready = 1'b1;
    miss_req = 1'b1; miss_addr = 32'h0000_2040;
    @(negedge clk); miss_req = 1'b0;
    nacc = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req) begin
        check($sformatf("t4_addr%0d", nacc), 64'(mem_addr), 64'(32'h2040 + 32'(4*nacc)));
        nacc++;
      end
      miss_req = 1'b0;
      if (c == 2) begin miss_req = 1'b1; miss_addr = 32'h0000_7777; end
      if (refill_done) begin seen = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_3000; end
      @(negedge clk);
      if (seen) break;
    end
    miss_req = 1'b0;
    check("t4_done_seen", 64'(seen), 64'h1);
    check("t4_words", 64'(nacc), 64'd16);
    check("t4_cache_addr", 64'(cache_addr), 64'h2040);
    check("t4_tag", 64'(new_cache_line[LL-1 -: 21]), 64'h4);
    check("t4_b2b_outs", 64'(outs()), 64'({5'b11000, 32'h3000}));

    // Reset when the FETCH reaches word 8 aborts the refill.
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req && mem_addr == 32'h3020) begin seen = 1'b1; rst = 1'b1; end
      @(negedge clk);
      if (seen) break;
    end
    rst = 1'b0;
    check("t5_reached_word8", 64'(seen), 64'h1);
    check("t5_rst_outs", 64'(outs()), 64'h0);
    check("t5_rst_line_zero", 64'(|new_cache_line), 64'h0);
    check("t5_rst_cache_addr", 64'(cache_addr), 64'h0);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (full_line_wr || refill_done || refill_err || busy) cnt++;
    end
    check("t5_no_pulses_after_rst", 64'(cnt), 64'd0);

    // A new miss after the reset completes normally.
    miss_req = 1'b1; miss_addr = 32'h0000_5010;
    @(negedge clk); miss_req = 1'b0;
    nflw = 0; seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (full_line_wr) nflw++;
      if (refill_done) seen = 1'b1;
      @(negedge clk);
      if (seen) break;
    end
    check("t6_done_seen", 64'(seen), 64'h1);
    check("t6_flw_count", 64'(nflw), 64'd1);
    check("t6_cache_addr", 64'(cache_addr), 64'h5000);
    check("t6_word3", 64'(word_of(3)), 64'hA000_0003);
    check("t6_valid", 64'(new_cache_line[0]), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
